// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the two-requester program-ROM arbiter:
// requester encoding, FSM states and wait-state limits.
package rom_arbiter_pkg;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_LD = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int unsigned WAIT_MAX = 15;
    localparam int          CNT_W    = 4;

endpackage

// File: rtl/rom_arbiter_if.sv
// Bundle of the fetch, load and ROM-side signals around rom_arbiter.
// slave = arbiter view, master = requesters plus ROM.
interface rom_arbiter_if #(
    parameter int unsigned ROM_WIDTH  = 26,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic [ROM_WIDTH-1:0]  if_rdata;
    logic                  if_rvalid;

    logic                  ld_req;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic                  ld_gnt;
    logic [ROM_WIDTH-1:0]  ld_rdata;
    logic                  ld_rvalid;

    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [ROM_WIDTH-1:0]  rom_data;

    modport slave (
        input  if_req, if_addr, ld_req, ld_addr, rom_data,
        output if_gnt, if_rdata, if_rvalid,
        output ld_gnt, ld_rdata, ld_rvalid,
        output rom_addr
    );

    modport master (
        output if_req, if_addr, ld_req, ld_addr, rom_data,
        input  if_gnt, if_rdata, if_rvalid,
        input  ld_gnt, ld_rdata, ld_rvalid,
        input  rom_addr
    );
endinterface

// File: rtl/rom_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic. On a conflict the requester that
// did not win last time is granted; single requests always win.
module rr_arbiter2
    import rom_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_winner
);

    logic r_last_owner;
    logic w_winner;

    // NOTE: every combinational output gets a default before any branch,
    // otherwise a missed path infers a latch.
    always_comb begin
        w_winner = REQ_IF;
        if (i_req == 2'b11) begin
            w_winner = (r_last_owner == REQ_IF) ? REQ_LD : REQ_IF;
        end else if (i_req[REQ_LD]) begin
            w_winner = REQ_LD;
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        if (i_en && i_req[w_winner]) begin
            o_gnt[w_winner] = 1'b1;
        end
    end

    assign o_winner = w_winner;

    // NOTE: state registers use non-blocking assignments so all flops
    // update together at the edge, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_owner <= REQ_LD;
        end else if (|o_gnt) begin
            r_last_owner <= w_winner;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one combinational program ROM between instruction fetch and
// data load, with programmable wait states and registered read data.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned ROM_WIDTH   = 26,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic          i_clk,
    input logic          i_rst_n,
    rom_arbiter_if.slave bus
);

    generate
        if (WAIT_STATES > WAIT_MAX) begin : g_bad_wait_states
            $error("rom_arbiter: WAIT_STATES must be in 0..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_owner;
    logic                  w_owner_nxt;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [ADDR_WIDTH-1:0] w_rom_addr_nxt;
    logic                  w_capture;

    logic [ROM_WIDTH-1:0]  r_if_rdata;
    logic [ROM_WIDTH-1:0]  r_ld_rdata;
    logic                  r_if_rvalid;
    logic                  r_ld_rvalid;

    logic                  w_arb_en;
    logic [1:0]            w_req;
    logic [1:0]            w_gnt;
    logic                  w_winner;

    // Grants are suppressed while reset is held so none leak out asynchronously.
    assign w_arb_en         = (r_state == IDLE) && i_rst_n;
    assign w_req[REQ_IF]    = bus.if_req;
    assign w_req[REQ_LD]    = bus.ld_req;

    rr_arbiter2 u_rr_arbiter2 (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (w_arb_en),
        .i_req    (w_req),
        .o_gnt    (w_gnt),
        .o_winner (w_winner)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_owner_nxt    = r_owner;
        w_rom_addr_nxt = r_rom_addr;
        w_capture      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_state_nxt    = ACCESS;
                    w_cnt_nxt      = WS_LOAD;
                    w_owner_nxt    = w_winner;
                    w_rom_addr_nxt = (w_winner == REQ_LD) ? bus.ld_addr : bus.if_addr;
                end
            end
            ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_capture   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_owner    <= REQ_IF;
            r_rom_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_owner    <= w_owner_nxt;
            r_rom_addr <= w_rom_addr_nxt;
        end
    end

    // NOTE: the read-data registers are reset because their zero value is
    // visible to both requesters before the first capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_rdata  <= '0;
            r_ld_rdata  <= '0;
            r_if_rvalid <= 1'b0;
            r_ld_rvalid <= 1'b0;
        end else begin
            r_if_rvalid <= w_capture && (r_owner == REQ_IF);
            r_ld_rvalid <= w_capture && (r_owner == REQ_LD);
            if (w_capture && (r_owner == REQ_IF)) begin
                r_if_rdata <= bus.rom_data;
            end
            if (w_capture && (r_owner == REQ_LD)) begin
                r_ld_rdata <= bus.rom_data;
            end
        end
    end

    assign bus.if_gnt    = w_gnt[REQ_IF];
    assign bus.ld_gnt    = w_gnt[REQ_LD];
    assign bus.if_rdata  = r_if_rdata;
    assign bus.ld_rdata  = r_ld_rdata;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.ld_rvalid = r_ld_rvalid;
    assign bus.rom_addr  = r_rom_addr;

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: one instance with no wait states,
// one with three, both reading a ROM model returning addr*3+1.
module tb_rom_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [25:0] q_if0[$];
    logic [25:0] q_ld0[$];
    logic [25:0] q_if3[$];
    logic [25:0] q_ld3[$];

    always #5 clk = ~clk;

    function automatic logic [25:0] rom_model(input logic [15:0] a);
        return {10'd0, a} * 26'd3 + 26'd1;
    endfunction

    rom_arbiter_if #(.ROM_WIDTH(26), .ADDR_WIDTH(16)) b0 ();
    rom_arbiter_if #(.ROM_WIDTH(26), .ADDR_WIDTH(16)) b3 ();

    assign b0.rom_data = rom_model(b0.rom_addr);
    assign b3.rom_data = rom_model(b3.rom_addr);

    rom_arbiter #(.ROM_WIDTH(26), .ADDR_WIDTH(16), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b0.slave)
    );
    rom_arbiter #(.ROM_WIDTH(26), .ADDR_WIDTH(16), .WAIT_STATES(3)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b3.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 4; c++) begin
            tick();
            b0.if_req = 1'($urandom_range(0, 1)); b0.if_addr = 16'($urandom);
            b0.ld_req = 1'($urandom_range(0, 1)); b0.ld_addr = 16'($urandom);
            b3.if_req = 1'($urandom_range(0, 1)); b3.if_addr = 16'($urandom);
            b3.ld_req = 1'($urandom_range(0, 1)); b3.ld_addr = 16'($urandom);
            #1;
            n_checks++;
            if ({b0.if_gnt, b0.ld_gnt, b0.if_rvalid, b0.ld_rvalid,
                 b3.if_gnt, b3.ld_gnt, b3.if_rvalid, b3.ld_rvalid} !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_ctrl c=%0d got b0=%b%b%b%b b3=%b%b%b%b want all 0", c,
                         b0.if_gnt, b0.ld_gnt, b0.if_rvalid, b0.ld_rvalid,
                         b3.if_gnt, b3.ld_gnt, b3.if_rvalid, b3.ld_rvalid);
            end
            n_checks++;
            if ({b0.if_rdata, b0.ld_rdata, b0.rom_addr,
                 b3.if_rdata, b3.ld_rdata, b3.rom_addr} !== '0) begin
                n_errors++;
                $display("FAIL reset_data c=%0d got b0 rom_addr=%h if=%h ld=%h want 0", c,
                         b0.rom_addr, b0.if_rdata, b0.ld_rdata);
            end
        end
        tick();
        {b0.if_req, b0.ld_req, b3.if_req, b3.ld_req} = 4'b0000;
        rst_n = 1'b1;
    endtask

    // IF(2) and LD(5) held together: grants IF, LD, IF two cycles apart.
    task automatic test_round_robin();
        logic [1:0]  gnt_tab [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
        logic [1:0]  rv_tab  [7] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
        logic [25:0] exp;
        for (int c = 0; c < 7; c++) begin
            tick();
            b0.if_req = (c <= 4); b0.if_addr = 16'd2;
            b0.ld_req = (c <= 4); b0.ld_addr = 16'd5;
            #1;
            n_checks++;
            if ({b0.ld_gnt, b0.if_gnt} !== gnt_tab[c]) begin
                n_errors++;
                $display("FAIL rr_gnt c=%0d got {ld,if}=%b want %b", c, {b0.ld_gnt, b0.if_gnt}, gnt_tab[c]);
            end
            n_checks++;
            if ({b0.ld_rvalid, b0.if_rvalid} !== rv_tab[c]) begin
                n_errors++;
                $display("FAIL rr_rvalid c=%0d got {ld,if}=%b want %b", c, {b0.ld_rvalid, b0.if_rvalid}, rv_tab[c]);
            end
            if (rv_tab[c][0]) begin
                exp = (q_if0.size() != 0) ? q_if0.pop_front() : 'x;
                n_checks++;
                if (b0.if_rdata !== exp) begin
                    n_errors++;
                    $display("FAIL rr_if_rdata c=%0d got %0d want %0d", c, b0.if_rdata, exp);
                end
            end
            if (rv_tab[c][1]) begin
                exp = (q_ld0.size() != 0) ? q_ld0.pop_front() : 'x;
                n_checks++;
                if (b0.ld_rdata !== exp) begin
                    n_errors++;
                    $display("FAIL rr_ld_rdata c=%0d got %0d want %0d", c, b0.ld_rdata, exp);
                end
            end
            if (gnt_tab[c][0]) q_if0.push_back(rom_model(b0.if_addr));
            if (gnt_tab[c][1]) q_ld0.push_back(rom_model(b0.ld_addr));
        end
        {b0.if_req, b0.ld_req} = 2'b00;
    endtask

    task automatic test_single_if();
        logic [25:0] exp;
        tick();
        b0.if_req = 1'b1; b0.if_addr = 16'd8;
        #1;
        n_checks++;
        if ({b0.ld_gnt, b0.if_gnt} !== 2'b01) begin
            n_errors++;
            $display("FAIL single_gnt got {ld,if}=%b want 01", {b0.ld_gnt, b0.if_gnt});
        end
        q_if0.push_back(rom_model(16'd8));
        tick();
        b0.if_req = 1'b0;
        #1;
        n_checks++;
        if (b0.rom_addr !== 16'd8 || b0.if_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_addr got rom_addr=%0d rvalid=%b want 8 0", b0.rom_addr, b0.if_rvalid);
        end
        tick();
        #1;
        exp = (q_if0.size() != 0) ? q_if0.pop_front() : 'x;
        n_checks++;
        if (b0.if_rvalid !== 1'b1 || b0.if_rdata !== exp) begin
            n_errors++;
            $display("FAIL single_data got rvalid=%b rdata=%0d want 1 %0d", b0.if_rvalid, b0.if_rdata, exp);
        end
        n_checks++;
        if (b0.ld_rvalid !== 1'b0 || b0.ld_rdata !== 26'd16) begin
            n_errors++;
            $display("FAIL single_ld_untouched got rvalid=%b rdata=%0d want 0 16", b0.ld_rvalid, b0.ld_rdata);
        end
        tick();
        #1;
        n_checks++;
        if (b0.if_rvalid !== 1'b0 || b0.if_rdata !== 26'd25) begin
            n_errors++;
            $display("FAIL single_pulse got rvalid=%b rdata=%0d want 0 25", b0.if_rvalid, b0.if_rdata);
        end
    endtask

    // IF asks for addr 1 then addr 4; second grant lands on the first RVALID.
    task automatic test_back_to_back();
        logic [25:0] exp;
        for (int c = 0; c < 5; c++) begin
            tick();
            b0.if_req  = (c <= 2);
            b0.if_addr = (c == 0) ? 16'd1 : 16'd4;
            #1;
            n_checks++;
            if (b0.if_gnt !== (c == 0 || c == 2)) begin
                n_errors++;
                $display("FAIL b2b_gnt c=%0d got %b want %b", c, b0.if_gnt, (c == 0 || c == 2));
            end
            n_checks++;
            if (b0.if_rvalid !== (c == 2 || c == 4)) begin
                n_errors++;
                $display("FAIL b2b_rvalid c=%0d got %b want %b", c, b0.if_rvalid, (c == 2 || c == 4));
            end
            if (c == 2 || c == 4) begin
                exp = (q_if0.size() != 0) ? q_if0.pop_front() : 'x;
                n_checks++;
                if (b0.if_rdata !== exp) begin
                    n_errors++;
                    $display("FAIL b2b_rdata c=%0d got %0d want %0d", c, b0.if_rdata, exp);
                end
            end
            if (c == 0 || c == 2) q_if0.push_back(rom_model(b0.if_addr));
        end
        b0.if_req = 1'b0;
    endtask

    // WAIT_STATES=3: LD addr 10 held on ROM for four cycles, a queued
    // second LD (addr 11) waits until the first RVALID.
    task automatic test_wait_states();
        logic [25:0] exp;
        for (int c = 0; c < 11; c++) begin
            tick();
            b3.ld_req  = (c <= 5);
            b3.ld_addr = (c == 0) ? 16'd10 : 16'd11;
            #1;
            n_checks++;
            if (b3.ld_gnt !== (c == 0 || c == 5) || b3.if_gnt !== 1'b0) begin
                n_errors++;
                $display("FAIL ws_gnt c=%0d got ld=%b if=%b want %b 0", c, b3.ld_gnt, b3.if_gnt, (c == 0 || c == 5));
            end
            n_checks++;
            if (b3.ld_rvalid !== (c == 5 || c == 10)) begin
                n_errors++;
                $display("FAIL ws_rvalid c=%0d got %b want %b", c, b3.ld_rvalid, (c == 5 || c == 10));
            end
            if (c >= 1 && c <= 4) begin
                n_checks++;
                if (b3.rom_addr !== 16'd10) begin
                    n_errors++;
                    $display("FAIL ws_rom_addr c=%0d got %0d want 10", c, b3.rom_addr);
                end
            end
            if (c == 5 || c == 10) begin
                exp = (q_ld3.size() != 0) ? q_ld3.pop_front() : 'x;
                n_checks++;
                if (b3.ld_rdata !== exp) begin
                    n_errors++;
                    $display("FAIL ws_rdata c=%0d got %0d want %0d", c, b3.ld_rdata, exp);
                end
            end
            if (c == 0 || c == 5) q_ld3.push_back(rom_model(b3.ld_addr));
        end
        b3.ld_req = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        logic        saw_rvalid = 1'b0;
        logic [25:0] exp;
        tick();
        b3.if_req = 1'b1; b3.if_addr = 16'd7;
        #1;
        n_checks++;
        if (b3.if_gnt !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_gnt got %b want 1", b3.if_gnt);
        end
        tick();
        b3.if_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (b3.rom_addr !== 16'd0 || b3.if_rvalid !== 1'b0 || b3.ld_rdata !== 26'd0) begin
            n_errors++;
            $display("FAIL mid_reset got rom_addr=%0d rvalid=%b ld_rdata=%0d want 0 0 0",
                     b3.rom_addr, b3.if_rvalid, b3.ld_rdata);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            saw_rvalid = saw_rvalid | b3.if_rvalid | b3.ld_rvalid;
        end
        n_checks++;
        if (saw_rvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_dropped got rvalid=%b want 0", saw_rvalid);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            b3.if_req = (c == 0); b3.if_addr = 16'd9;
            #1;
            n_checks++;
            if (b3.if_gnt !== (c == 0) || b3.if_rvalid !== (c == 5)) begin
                n_errors++;
                $display("FAIL mid_after c=%0d got gnt=%b rvalid=%b want %b %b", c,
                         b3.if_gnt, b3.if_rvalid, (c == 0), (c == 5));
            end
            if (c == 0) q_if3.push_back(rom_model(16'd9));
            if (c == 5) begin
                exp = (q_if3.size() != 0) ? q_if3.pop_front() : 'x;
                n_checks++;
                if (b3.if_rdata !== exp) begin
                    n_errors++;
                    $display("FAIL mid_after_rdata got %0d want %0d", b3.if_rdata, exp);
                end
            end
        end
        b3.if_req = 1'b0;
    endtask

    initial begin
        {b0.if_req, b0.ld_req, b3.if_req, b3.ld_req} = 4'b0000;
        {b0.if_addr, b0.ld_addr, b3.if_addr, b3.ld_addr} = '0;
        test_reset();
        test_round_robin();
        test_single_if();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_access();
        n_checks++;
        if (q_if0.size() + q_ld0.size() + q_if3.size() + q_ld3.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0",
                     q_if0.size() + q_ld0.size() + q_if3.size() + q_ld3.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
